// File: rtl/accel_pkg.sv
// accel_pkg: shared widths, FSM state type and saturation bounds for the accumulator slice
`ifndef IF_BITWIDTH
`define IF_BITWIDTH 8
`endif
`ifndef OF_BITWIDTH
`define OF_BITWIDTH 16
`endif

package accel_pkg;
    localparam int IF_WIDTH = `IF_BITWIDTH;
    localparam int OF_WIDTH = `OF_BITWIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/psum_requant.sv
// psum_requant: round-half-up arithmetic right shift of a wide sum, saturated to IF_W bits
module psum_requant
    import accel_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int IF_W  = 8
) (
    input  logic signed [ACC_W-1:0] i_sum,
    input  logic        [4:0]       i_shift,
    output logic signed [IF_W-1:0]  o_data,
    output logic                    o_sat
);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'(sat_max(IF_W));
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W + 1)'(sat_min(IF_W));

    logic signed [ACC_W:0] w_ext, w_rnd, w_sh, w_r;

    // one extra bit of headroom keeps the rounding add from wrapping; huge shifts collapse to the sign
    always_comb begin
        w_ext  = {i_sum[ACC_W-1], i_sum};
        w_rnd  = (i_shift == 5'd0) ? '0 : ((ACC_W + 1)'(1) << (i_shift - 5'd1));
        w_sh   = (w_ext + w_rnd) >>> i_shift;
        w_r    = (32'(i_shift) >= ACC_W) ? {(ACC_W + 1){i_sum[ACC_W-1]}} : w_sh;
        o_sat  = (w_r > MAX_V) || (w_r < MIN_V);
        o_data = (w_r > MAX_V) ? MAX_V[IF_W-1:0] : (w_r < MIN_V) ? MIN_V[IF_W-1:0] : w_r[IF_W-1:0];
    end
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates num_tiles partial sums, requantizes and emits via valid/ready
module psum_accumulator
    import accel_pkg::*;
#(
    parameter int IF_W  = IF_WIDTH,
    parameter int OF_W  = OF_WIDTH,
    parameter int CNT_W = 4,
    parameter int ACC_W = OF_W + CNT_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic        [CNT_W-1:0] num_tiles,
    input  logic        [4:0]       shift,
    input  logic                    in_valid,
    input  logic signed [OF_W-1:0]  in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [IF_W-1:0]  out_data,
    output logic                    out_sat,
    input  logic                    out_ready
);
    state_t                  r_state, w_next;
    logic signed [ACC_W-1:0] r_acc, w_sum;
    logic        [CNT_W-1:0] r_cnt, r_tiles;
    logic        [4:0]       r_shift;
    logic                    r_out_valid, r_out_sat;
    logic signed [IF_W-1:0]  r_out_data;
    logic                    w_accept, w_last, w_take, w_sat;
    logic signed [IF_W-1:0]  w_q;

    assign in_ready  = (r_state == ACCUM) && enable;
    assign w_accept  = in_ready && in_valid;
    assign w_sum     = r_acc + ACC_W'(in_data);
    assign w_last    = (r_cnt + 1'b1) == r_tiles;
    assign w_take    = (r_state == EMIT) && enable && out_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    psum_requant #(.ACC_W(ACC_W), .IF_W(IF_W)) u_requant (
        .i_sum  (w_sum),
        .i_shift(r_shift),
        .o_data (w_q),
        .o_sat  (w_sat)
    );

    // next state: clear wins, stall freezes, otherwise follow beat count and handshake
    always_comb begin
        w_next = r_state;
        if (clear)
            w_next = IDLE;
        else if (enable)
            case (r_state)
                IDLE:    w_next = ACCUM;
                ACCUM:   w_next = (w_accept && w_last) ? EMIT : ACCUM;
                EMIT:    w_next = w_take ? ACCUM : EMIT;
                default: w_next = IDLE;
            endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;

    // datapath: config latch on IDLE exit, accumulate beats, register the requantized result
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_tiles     <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (enable) begin
            if (r_state == IDLE) begin
                r_tiles <= (num_tiles == '0) ? CNT_W'(1) : num_tiles;
                r_shift <= shift;
            end
            if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept && w_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_q;
                r_out_sat   <= w_sat;
            end
            if (w_take) begin
                r_out_valid <= 1'b0;
                r_acc       <= '0;
                r_cnt       <= '0;
            end
        end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed plus randomized checks against a queue-based reference model
module tb_psum_accumulator;
    import accel_pkg::*;
    localparam int IF_W  = IF_WIDTH;
    localparam int OF_W  = OF_WIDTH;
    localparam int CNT_W = 4;
    localparam int ACC_W = OF_W + CNT_W;

    logic                   clock = 0, reset_n = 0, enable = 0, clear = 0;
    logic                   in_valid = 0, out_ready = 0;
    logic       [CNT_W-1:0] num_tiles = 0;
    logic       [4:0]       shift = 0;
    logic signed [OF_W-1:0] in_data = 0;
    logic                   in_ready, out_valid, out_sat;
    logic signed [IF_W-1:0] out_data;
    int                     errors = 0, checks = 0;

    psum_accumulator dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .num_tiles(num_tiles), .shift(shift), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sat(out_sat), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // reference requantization straight from the arithmetic definition
    function automatic void requant(input longint s, input int sh, output longint d, output bit sat);
        longint r, hi, lo;
        hi = (64'sd1 <<< (IF_W - 1)) - 1;
        lo = -(64'sd1 <<< (IF_W - 1));
        if (sh >= ACC_W) r = (s < 0) ? -1 : 0;
        else r = (s + ((sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0)) >>> sh;
        sat = (r > hi) || (r < lo);
        d = (r > hi) ? hi : (r < lo) ? lo : r;
    endfunction

    function automatic longint total(input longint q[$]);
        longint s;
        s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    // model: 0 = waiting for config, 1 = collecting beats, 2 = presenting a result
    int          m_phase = 0, m_tiles = 1, m_shift = 0;
    longint      beats[$];
    bit          m_valid = 0, m_sat = 0;
    longint      m_data = 0;

    // compare process: check outputs, then advance the model with the inputs the next edge will see
    always @(negedge clock) begin
        if (!reset_n) begin
            m_phase = 0; m_valid = 0; m_sat = 0; m_data = 0;
            beats.delete();
        end
        chk("in_ready", in_ready, (m_phase == 1) && enable);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_sat", out_sat, m_sat);
        if (reset_n) begin
            if (clear) begin
                m_phase = 0; m_valid = 0; m_sat = 0;
                beats.delete();
            end else if (enable) begin
                if (m_phase == 0) begin
                    m_tiles = (num_tiles == 0) ? 1 : int'(num_tiles);
                    m_shift = int'(shift);
                    m_phase = 1;
                end else if (m_phase == 1 && in_valid) begin
                    beats.push_back(longint'(in_data));
                    if (beats.size() == m_tiles) begin
                        requant(total(beats), m_shift, m_data, m_sat);
                        m_valid = 1;
                        m_phase = 2;
                    end
                end else if (m_phase == 2 && out_ready) begin
                    m_valid = 0;
                    beats.delete();
                    m_phase = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic configure(input int t, input int sh);
        num_tiles = CNT_W'(t);
        shift = 5'(sh);
        enable = 1;
        clear = 1;
        tick();
        clear = 0;
        tick();
    endtask

    task automatic beat(input int v);
        bit ok;
        int n;
        ok = 0;
        n = 0;
        in_valid = 1;
        in_data = OF_W'(v);
        while (!ok && n < 50) begin
            @(negedge clock);
            ok = in_ready;
            tick();
            n++;
        end
        if (!ok) chk("beat_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic result(input string name, input longint d, input bit s);
        int n;
        n = 0;
        out_ready = 1;
        @(negedge clock);
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_sat"}, out_sat, s);
        tick();
        out_ready = 0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_ready", in_ready, 0);
        reset_n = 1;

        configure(3, 0);
        beat(1); beat(3);
        chk("t1_not_early", out_valid, 0);
        beat(5);
        chk("t1_latency", out_valid, 1);
        result("t1", 9, 0);

        configure(2, 2);
        beat(10); beat(-3);
        result("t2_pos", 2, 0);
        beat(-4); beat(-3);
        result("t2_neg", -2, 0);

        configure(2, 0);
        beat(120); beat(121);
        result("t3_max", 127, 1);
        beat(-122); beat(-10);
        result("t3_min", -128, 1);

        beat(7); beat(8);
        in_valid = 1;
        in_data = 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", out_data, 15);
            chk("t4_hold_ready", in_ready, 0);
            tick();
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        beat(2); beat(2);
        result("t4_next", 4, 0);

        configure(0, 0);
        beat(-5);
        chk("t5_valid", out_valid, 1);
        chk("t5_data", out_data, -5);
        result("t5", -5, 0);

        configure(3, 0);
        beat(1); beat(1);
        reset_n = 0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_sat", out_sat, 0);
        chk("t6_rst_ready", in_ready, 0);
        tick();
        reset_n = 1;
        beat(1); beat(1); beat(1);
        result("t6_rst", 3, 0);

        configure(3, 0);
        beat(1); beat(1);
        clear = 1;
        tick();
        chk("t6_clr_valid", out_valid, 0);
        chk("t6_clr_ready", in_ready, 0);
        clear = 0;
        beat(1); beat(1); beat(1);
        result("t6_clr", 3, 0);

        beat(1); beat(1); beat(1);
        chk("t6_emit_valid", out_valid, 1);
        clear = 1;
        out_ready = 1;
        tick();
        chk("t6_both_valid", out_valid, 0);
        chk("t6_both_ready", in_ready, 0);
        clear = 0;
        out_ready = 0;
        tick();

        for (int c = 0; c < 600; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_data = $urandom_range(0, 1) ? OF_W'($urandom) : OF_W'(int'($urandom_range(0, 400)) - 200);
            out_ready = $urandom_range(0, 1);
            clear = ($urandom_range(0, 49) == 0);
            reset_n = ($urandom_range(0, 149) != 0);
            num_tiles = CNT_W'($urandom_range(0, 6));
            shift = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
            tick();
        end
        reset_n = 1;
        clear = 0;
        in_valid = 0;
        out_ready = 0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream stage of a processing_element column.
- Consumes the PE's data_out partial sums over a configurable number of K-tiles and accumulates them at full precision.
- Requantizes each finished sum to IF_W bits with round-half-up and saturation, then emits it through a valid/ready handshake.
- The emitted value feeds the next layer's activation input.

Parameters:
- IF_W, `IF_BITWIDTH, width of the requantized output (activation width).
- OF_W, `OF_BITWIDTH, width of incoming partial sums from the PE.
- CNT_W, 4, width of the tile-count configuration.
- ACC_W, OF_W+CNT_W, accumulator width; cannot overflow for num_tiles up to 2^CNT_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  global stall; low freezes all state.
- clear  in  1  synchronous abort: return to IDLE, discard accumulation.
- num_tiles  in  CNT_W  beats per output; sampled on leaving IDLE.
- shift  in  5  right-shift amount for requantization; sampled on leaving IDLE.
- in_valid  in  1  partial sum present.
- in_data  in  OF_W  signed partial sum.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_valid  out  1  requantized result present.
- out_data  out  IF_W  signed requantized result.
- out_sat  out  1  result was saturated.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

Behaviour:
- Clock is clock; reset is reset_n, asynchronous, active-low.
- Reset values:
  - state=IDLE
  - acc=0, beat count=0
  - out_valid=0, out_data=0, out_sat=0
  - in_ready=0
- FSM states:
  - IDLE: if enable, latch num_tiles (0 treated as 1) and shift, go to ACCUM.
  - ACCUM: in_ready = enable.
    - On accept, acc += sign-extended in_data and count increments.
    - On the beat that reaches num_tiles, register out_data/out_sat from (acc + in_data), set out_valid, go to EMIT.
  - EMIT: in_ready=0; out_valid, out_data and out_sat are held stable until out_ready.
    - On handshake, out_valid=0, acc=0, count=0, go to ACCUM; the latched config is kept.
- Latency:
  - out_valid rises the cycle after the last beat is accepted.
  - No beats are accepted in the handshake cycle; the earliest next accept is one cycle after that.
- Requantization, performed on the ACC_W-bit sum S:
  - R = (S + (shift>0 ? 2^(shift-1) : 0)) >>> shift, arithmetic shift.
  - shift >= ACC_W yields 0 or -1 according to the sign of S.
  - If R > 2^(IF_W-1)-1: out_data = max and out_sat=1.
  - If R < -2^(IF_W-1): out_data = min and out_sat=1.
  - Otherwise out_data = R and out_sat=0.
- enable low: no state change, in_ready=0; out_valid and out_data are held. Handshakes are ignored while enable=0.
- clear: takes priority over every other event in the same cycle. Go to IDLE, acc=0, count=0, out_valid=0, out_sat=0.
- Changes to num_tiles/shift during ACCUM/EMIT have no effect until the next IDLE exit.
- in_data arriving while in_valid=0 is ignored.
- An in_valid beat presented during EMIT is not consumed and must be held by the producer.
- Reset mid-operation clears everything immediately (asynchronous); the partial result is lost.

Decomposition:
- Package accel_pkg holds:
  - the state enum (IDLE/ACCUM/EMIT),
  - IF/OF width localparams derived from the macros,
  - the saturation min/max constant functions.
- Sub-module psum_requant: combinational round/shift/saturate taking ACC_W input, shift and IF_W, producing data and sat.

Test Plan:
1. Sum and latency. Settings: IF_W=8, OF_W=16, num_tiles=3, shift=0. Beats 1,3,5 -> out_data=9, out_sat=0, out_valid exactly 1 cycle after the third accept.
2. Rounding. num_tiles=2, shift=2.
   - Beats 10,-3 (S=7) -> out_data=2.
   - Beats -4,-3 (S=-7) -> out_data=-2.
3. Saturation. num_tiles=2, shift=0.
   - Beats 120,121 -> out_data=127, out_sat=1.
   - Beats -122,-10 -> out_data=-128, out_sat=1.
4. Backpressure. out_ready held low 5 cycles with in_valid=1 -> out_valid and out_data stable, in_ready=0, no beat consumed. After the handshake, the next group 2,2 (num_tiles=2) -> 4, with no residue from the prior sum.
5. Tile count zero. num_tiles=0 -> behaves as 1: single beat -5 with shift 0 -> out_data=-5 the following cycle.
6. Abort paths.
   - reset_n pulsed low after 2 of 3 beats -> all outputs 0 at once, state IDLE. A fresh 3-beat group 1,1,1 -> 3.
   - The same sequence using clear instead of reset gives the identical result.
   - clear and out_ready asserted together in EMIT -> IDLE, out_valid=0.
